mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the instruction-fetch and MEM-stage requesters
module mem_port_arbiter #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int MAX_MEM_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              err
);

    localparam int RUN_W  = $clog2(MAX_MEM_RUN + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_MEM_RUN);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_mem;
    logic [RUN_W-1:0]  run_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              grant_mem;
    logic              grant_if;
    logic              in_acc;
    logic              acc_ack;
    logic              acc_timeout;

    assign stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    always_comb begin
        grant_mem   = 1'b0;
        grant_if    = 1'b0;
        in_acc      = (state == MEM_ACC) || (state == IF_ACC);
        acc_ack     = in_acc && ram_ack;
        acc_timeout = in_acc && !ram_ack && (wait_cnt == WAIT_LAST);
        state_nxt   = state;
        case (state)
            IDLE: begin
                // MEM wins unless IF has already waited through a full run of MEM grants
                grant_mem = mem_req && (!if_req || (run_cnt < RUN_MAX));
                grant_if  = !grant_mem && if_req;
                if (grant_mem) begin
                    state_nxt = MEM_ACC;
                end else if (grant_if) begin
                    state_nxt = IF_ACC;
                end
            end
            MEM_ACC, IF_ACC: begin
                if (acc_ack || acc_timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            err       <= 1'b0;
            owner_mem <= 1'b0;
            run_cnt   <= '0;
            wait_cnt  <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;

            if (grant_mem) begin
                ram_en    <= 1'b1;
                ram_we    <= mem_we;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
                owner_mem <= 1'b1;
                wait_cnt  <= '0;
                if (!if_req) begin
                    run_cnt <= '0;
                end else if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + RUN_W'(1);
                end
            end else if (grant_if) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b0;
                ram_addr  <= if_addr;
                ram_wdata <= '0;
                owner_mem <= 1'b0;
                wait_cnt  <= '0;
                run_cnt   <= '0;
            end else if (state == IDLE) begin
                run_cnt <= '0;
            end

            if (acc_ack || acc_timeout) begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                if (owner_mem) begin
                    mem_ready <= 1'b1;
                end else begin
                    if_ready <= 1'b1;
                end
                if (acc_ack) begin
                    // a store leaves the previous load data visible on mem_rdata
                    if (owner_mem && !ram_we) begin
                        mem_rdata <= ram_rdata;
                    end else if (!owner_mem) begin
                        if_rdata <= ram_rdata;
                    end
                end else begin
                    err <= 1'b1;
                    if (owner_mem) begin
                        mem_rdata <= '0;
                    end else begin
                        if_rdata <= '0;
                    end
                end
            end else if (in_acc) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [63:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        stall;
    logic        ram_en;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;
    logic        ram_ack;
    logic        err;

    mem_port_arbiter #(
        .DATA_W(64), .ADDR_W(64), .MAX_MEM_RUN(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_mem;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;
    int   cyc    = 0;
    int   ack_lat = 1;
    int   acc_cyc = 0;
    logic ack_en  = 1'b1;
    logic stray   = 1'b0;

    function automatic logic [63:0] model(input logic [63:0] a);
        if (a == 64'h100) return 64'h0000_0000_00A0_0093;
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (n_done < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(n_done >= target), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory responder: acks ack_lat cycles into each access
    always @(negedge clk) begin
        if (ram_en && ack_en) begin
            acc_cyc = acc_cyc + 1;
            if (acc_cyc == ack_lat) begin
                ram_ack   = 1'b1;
                ram_rdata = model(ram_addr);
            end else begin
                ram_ack = 1'b0;
            end
        end else begin
            acc_cyc = 0;
            ram_ack = stray;
        end
    end

    // scoreboard: every ready pulse pops one expectation
    always @(negedge clk) begin
        if (rst_n && (if_ready || mem_ready)) begin
            exp_t e;
            check("one_ready", 64'(if_ready & mem_ready), 64'd0);
            n_vec++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_ready: observed if=%0b mem=%0b expected none", if_ready, mem_ready);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("owner", 64'(mem_ready), 64'(e.is_mem));
                check("rdata", mem_ready ? mem_rdata : if_rdata, e.data);
            end
            n_done++;
        end
    end

    initial begin
        int c_mem;
        int c_if;
        int n_mem;
        int n_en;
        int base;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; ram_rdata = '0; ram_ack = 1'b0;
        #3;
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", ram_addr, 64'd0);
        check("rst_ready", 64'({if_ready, mem_ready}), 64'd0);
        check("rst_rdata", if_rdata | mem_rdata, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_stall", 64'(stall), 64'd0);

        // fetch
        base = n_done;
        if_req = 1'b1; if_addr = 64'h100;
        exp_q.push_back('{1'b0, 64'h00A0_0093});
        @(posedge clk); #1;
        check("fetch_en", 64'(ram_en), 64'd1);
        check("fetch_addr", ram_addr, 64'h100);
        check("fetch_we", 64'(ram_we), 64'd0);
        check("fetch_stall", 64'(stall), 64'd1);
        check("fetch_early_ready", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        check("fetch_ready", 64'(if_ready), 64'd1);
        check("fetch_data", if_rdata, 64'h00A0_0093);
        check("fetch_en_drop", 64'(ram_en), 64'd0);
        check("fetch_stall_drop", 64'(stall), 64'd0);
        if_req = 1'b0;
        @(posedge clk); #1;
        check("fetch_pulse_end", 64'(if_ready), 64'd0);
        wait_done(base + 1, "fetch_done");

        // collision: MEM first, IF right after DONE->IDLE
        @(negedge clk);
        base = n_done;
        c_mem = -1; c_if = -1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h200;
        if_req = 1'b1; if_addr = 64'h180;
        exp_q.push_back('{1'b1, model(64'h200)});
        exp_q.push_back('{1'b0, model(64'h180)});
        for (int k = 0; k < 30 && c_if < 0; k++) begin
            @(negedge clk);
            if (mem_ready) begin c_mem = cyc; mem_req = 1'b0; end
            if (if_ready) begin c_if = cyc; if_req = 1'b0; end
            else check("coll_stall", 64'(stall), 64'd1);
        end
        check("coll_gap", 64'(c_if - c_mem), 64'd3);
        wait_done(base + 2, "coll_done");

        // starvation: four MEM grants, then IF
        base = n_done;
        n_mem = 0;
        mem_req = 1'b1; mem_addr = 64'h400;
        if_req = 1'b1; if_addr = 64'h500;
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, model(64'h400)});
        exp_q.push_back('{1'b0, model(64'h500)});
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_ready) n_mem++;
            if (if_ready) begin
                if_req = 1'b0; mem_req = 1'b0;
                break;
            end
        end
        check("starve_mem_run", 64'(n_mem), 64'd4);
        wait_done(base + 5, "starve_done");

        // store with a 3-cycle ack
        @(negedge clk);
        base = n_done;
        n_en = 0;
        ack_lat = 3;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h300; mem_wdata = 64'hDEAD_BEEF;
        exp_q.push_back('{1'b1, model(64'h400)});
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ram_en) begin
                n_en++;
                check("store_we", 64'(ram_we), 64'd1);
                check("store_wdata", ram_wdata, 64'hDEAD_BEEF);
                check("store_addr", ram_addr, 64'h300);
            end
            if (mem_ready) begin
                mem_req = 1'b0; mem_we = 1'b0;
                break;
            end
        end
        check("store_len", 64'(n_en), 64'd3);
        wait_done(base + 1, "store_done");
        ack_lat = 1;

        // stray ack while idle
        @(negedge clk);
        stray = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 1) stray = 1'b0;
            check("stray_quiet", 64'({ram_en, if_ready, mem_ready}), 64'd0);
        end

        // reset one cycle after grant
        ack_en = 1'b0;
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 64'h600;
        @(posedge clk); #1;
        check("rstmid_en", 64'(ram_en), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_en_drop", 64'(ram_en), 64'd0);
        check("rstmid_addr", ram_addr, 64'd0);
        mem_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rstmid_no_ready", 64'({if_ready, mem_ready}), 64'd0);
        end
        rst_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        base = n_done;
        if_req = 1'b1; if_addr = 64'h100;
        exp_q.push_back('{1'b0, 64'h00A0_0093});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_ready) begin if_req = 1'b0; break; end
        end
        wait_done(base + 1, "rstmid_fresh");
        check("rstmid_mem_rdata", mem_rdata, 64'd0);
        check("pre_timeout_err", 64'(err), 64'd0);

        // timeout with TIMEOUT=8
        ack_en = 1'b0;
        @(negedge clk);
        base = n_done;
        n_en = 0;
        if_req = 1'b1; if_addr = 64'h700;
        exp_q.push_back('{1'b0, 64'd0});
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ram_en) n_en++;
            if (if_ready) begin
                check("timeout_err", 64'(err), 64'd1);
                if_req = 1'b0;
                break;
            end
        end
        check("timeout_len", 64'(n_en), 64'd8);
        wait_done(base + 1, "timeout_done");
        ack_en = 1'b1;
        @(negedge clk);
        base = n_done;
        mem_req = 1'b1; mem_addr = 64'h800;
        exp_q.push_back('{1'b1, model(64'h800)});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_ready) begin mem_req = 1'b0; break; end
        end
        wait_done(base + 1, "post_timeout_done");
        check("err_sticky", 64'(err), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("err_reset", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
